// File: rtl/result_tx_ctrl.sv
// Serializes scalar or vector results into bytes (MSB byte first) for the UART
// transmitter, fetching vector elements from a synchronous result BRAM.
module result_tx_ctrl #(
  parameter int N_ELEMS      = 1024,
  parameter int ADDR_W       = 10,
  parameter int RES_W        = 16,
  parameter int RES_BYTES    = 2,
  parameter int SCALAR_W     = 32,
  parameter int SCALAR_BYTES = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                mode,
  input  logic [SCALAR_W-1:0] scalar_in,
  output logic                rd_en,
  output logic [ADDR_W-1:0]   rd_addr,
  input  logic [RES_W-1:0]    rd_data,
  output logic [7:0]          tx_data,
  output logic                tx_valid,
  input  logic                tx_ready,
  output logic                busy,
  output logic                done
);

  localparam int SH_BYTES = (SCALAR_BYTES > RES_BYTES) ? SCALAR_BYTES : RES_BYTES;
  localparam int SH_W     = SH_BYTES * 8;
  localparam int CNT_W    = (SH_BYTES > 1) ? $clog2(SH_BYTES) : 1;
  localparam logic [ADDR_W-1:0] LAST_ELEM = ADDR_W'(N_ELEMS - 1);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT_RD,
    LOAD,
    SEND,
    DONE
  } state_t;

  state_t             state, state_next;
  logic [SH_W-1:0]    sh, sh_next;
  logic [CNT_W-1:0]   byte_cnt, byte_cnt_next;
  logic [ADDR_W-1:0]  elem_cnt, elem_cnt_next;
  logic               mode_q, mode_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      sh       <= '0;
      byte_cnt <= '0;
      elem_cnt <= '0;
      mode_q   <= 1'b0;
    end else begin
      state    <= state_next;
      sh       <= sh_next;
      byte_cnt <= byte_cnt_next;
      elem_cnt <= elem_cnt_next;
      mode_q   <= mode_next;
    end
  end

  // Values are left-aligned in the shift register so the byte on air is always the top byte.
  always_comb begin
    state_next    = state;
    sh_next       = sh;
    byte_cnt_next = byte_cnt;
    elem_cnt_next = elem_cnt;
    mode_next     = mode_q;
    rd_en         = 1'b0;
    rd_addr       = '0;
    tx_valid      = 1'b0;
    tx_data       = '0;
    busy          = (state != IDLE);
    done          = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          mode_next = mode;
          if (mode) begin
            sh_next       = SH_W'(scalar_in) << ((SH_BYTES - SCALAR_BYTES) * 8);
            byte_cnt_next = CNT_W'(SCALAR_BYTES - 1);
            state_next    = SEND;
          end else begin
            elem_cnt_next = '0;
            state_next    = FETCH;
          end
        end
      end
      FETCH: begin
        rd_en      = 1'b1;
        rd_addr    = elem_cnt;
        state_next = WAIT_RD;
      end
      WAIT_RD: state_next = LOAD;
      LOAD: begin
        sh_next       = SH_W'(rd_data) << ((SH_BYTES - RES_BYTES) * 8);
        byte_cnt_next = CNT_W'(RES_BYTES - 1);
        state_next    = SEND;
      end
      SEND: begin
        tx_valid = 1'b1;
        tx_data  = sh[SH_W-1 -: 8];
        if (tx_ready) begin
          if (byte_cnt != '0) begin
            sh_next       = sh << 8;
            byte_cnt_next = byte_cnt - 1'b1;
          end else if (mode_q || (elem_cnt == LAST_ELEM)) begin
            state_next = DONE;
          end else begin
            elem_cnt_next = elem_cnt + 1'b1;
            state_next    = FETCH;
          end
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_result_tx_ctrl.sv
// Bench for result_tx_ctrl: byte-stream/address model plus cycle-pinned literal expectations.
module tb_result_tx_ctrl;

  localparam int S_TXD = 0, S_TXV = 1, S_BUSY = 2, S_DONE = 3, S_RDEN = 4, S_RDADDR = 5;
  localparam int S_NTXD = 6, S_NTXV = 7, S_NDONE = 8;

  typedef struct {
    int          cyc;
    int          sig;
    logic [31:0] val;
  } lit_t;

  logic        clk = 1'b0;
  logic        reset, start, mode, tx_ready;
  logic [31:0] scalar_in;
  logic        rd_en;
  logic [1:0]  rd_addr;
  logic [15:0] rd_data;
  logic [7:0]  tx_data;
  logic        tx_valid, busy, done;

  logic        n_start, n_mode, n_tx_ready;
  logic [31:0] n_scalar;
  logic        n_rd_en;
  logic [0:0]  n_rd_addr;
  logic [8:0]  n_rd_data;
  logic [7:0]  n_tx_data;
  logic        n_tx_valid, n_busy, n_done;

  logic [15:0] mem[4];
  logic [8:0]  n_mem[2];

  int          cyc = 0;
  int          t0 = 0;
  int          errors = 0, checks = 0;
  int          done_cnt = 0, done_exp = 0, n_done_cnt = 0;
  logic [7:0]  exp_q[$];
  logic [7:0]  n_exp_q[$];
  int          addr_q[$];
  lit_t        lit_q[$];
  logic        prev_stall = 1'b0, prev_done = 1'b0;
  logic [7:0]  prev_data = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];
  always @(posedge clk) if (n_rd_en) n_rd_data <= n_mem[n_rd_addr];

  result_tx_ctrl #(
    .N_ELEMS(4), .ADDR_W(2), .RES_W(16), .RES_BYTES(2), .SCALAR_W(32), .SCALAR_BYTES(4)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .scalar_in(scalar_in),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy), .done(done)
  );

  result_tx_ctrl #(
    .N_ELEMS(1), .ADDR_W(1), .RES_W(9), .RES_BYTES(2), .SCALAR_W(32), .SCALAR_BYTES(4)
  ) dut_narrow (
    .clk(clk), .reset(reset), .start(n_start), .mode(n_mode), .scalar_in(n_scalar),
    .rd_en(n_rd_en), .rd_addr(n_rd_addr), .rd_data(n_rd_data),
    .tx_data(n_tx_data), .tx_valid(n_tx_valid), .tx_ready(n_tx_ready), .busy(n_busy),
    .done(n_done)
  );

  function automatic string sig_name(input int s);
    case (s)
      S_TXD:    return "tx_data";
      S_TXV:    return "tx_valid";
      S_BUSY:   return "busy";
      S_DONE:   return "done";
      S_RDEN:   return "rd_en";
      S_RDADDR: return "rd_addr";
      S_NTXD:   return "narrow_tx_data";
      S_NTXV:   return "narrow_tx_valid";
      default:  return "narrow_done";
    endcase
  endfunction

  function automatic logic [31:0] sig_val(input int s);
    case (s)
      S_TXD:    return 32'(tx_data);
      S_TXV:    return 32'(tx_valid);
      S_BUSY:   return 32'(busy);
      S_DONE:   return 32'(done);
      S_RDEN:   return 32'(rd_en);
      S_RDADDR: return 32'(rd_addr);
      S_NTXD:   return 32'(n_tx_data);
      S_NTXV:   return 32'(n_tx_valid);
      default:  return 32'(n_done);
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic miss(input string name, input logic [31:0] act);
    checks++;
    errors++;
    $display("FAIL %s: got 0x%0h expected nothing (cycle %0d)", name, act, cyc);
  endtask

  task automatic lit(input int rel, input int sig, input logic [31:0] v);
    lit_t e;
    e.cyc = t0 + rel;
    e.sig = sig;
    e.val = v;
    lit_q.push_back(e);
  endtask

  // Expected byte stream: the value's bytes, most significant first.
  task automatic push_bytes(input logic [31:0] v, input int nb, input bit narrow);
    for (int b = nb - 1; b >= 0; b--) begin
      if (narrow) n_exp_q.push_back(8'((v >> (8 * b)) & 32'hFF));
      else        exp_q.push_back(8'((v >> (8 * b)) & 32'hFF));
    end
  endtask

  task automatic push_vector();
    for (int e = 0; e < 4; e++) begin
      push_bytes(32'(mem[e]), 2, 1'b0);
      addr_q.push_back(e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; mode = 1'b0; scalar_in = '0; tx_ready = 1'b1;
    n_start = 1'b0; n_mode = 1'b0; n_scalar = '0; n_tx_ready = 1'b1;
    mem[0] = 16'h0102; mem[1] = 16'h0304; mem[2] = 16'h0506; mem[3] = 16'h0708;
    n_mem[0] = 9'h1FF; n_mem[1] = 9'h000;

    fork
      forever begin
        @(negedge clk);
        for (int i = lit_q.size() - 1; i >= 0; i--) begin
          if (lit_q[i].cyc == cyc) begin
            chk(sig_name(lit_q[i].sig), sig_val(lit_q[i].sig), lit_q[i].val);
            lit_q.delete(i);
          end
        end
        if (reset) begin
          prev_stall = 1'b0;
          prev_done  = 1'b0;
        end else begin
          if (prev_stall) begin
            chk("hold_valid", 32'(tx_valid), 32'd1);
            chk("hold_data", 32'(tx_data), 32'(prev_data));
          end
          if (tx_valid && tx_ready) begin
            if (exp_q.size() == 0) miss("tx_extra", 32'(tx_data));
            else chk("tx_byte", 32'(tx_data), 32'(exp_q.pop_front()));
          end
          if (rd_en) begin
            if (addr_q.size() == 0) miss("rd_extra", 32'(rd_addr));
            else chk("rd_addr_seq", 32'(rd_addr), 32'(addr_q.pop_front()));
          end
          if (done) begin
            done_cnt++;
            if (prev_done) miss("done_width", 32'(done));
            if (tx_valid) miss("done_with_valid", 32'(tx_valid));
          end
          if (n_tx_valid && n_tx_ready) begin
            if (n_exp_q.size() == 0) miss("narrow_tx_extra", 32'(n_tx_data));
            else chk("narrow_tx_byte", 32'(n_tx_data), 32'(n_exp_q.pop_front()));
          end
          if (n_done) n_done_cnt++;
          prev_stall = tx_valid && !tx_ready;
          prev_data  = tx_data;
          prev_done  = done;
        end
      end
    join_none

    // Reset state
    tick(); tick(); tick();
    t0 = cyc;
    lit(0, S_TXV, 0); lit(0, S_BUSY, 0); lit(0, S_DONE, 0);
    lit(0, S_RDEN, 0); lit(0, S_RDADDR, 0); lit(0, S_TXD, 0);
    reset = 1'b0;
    tick();

    // Scalar, no backpressure
    t0 = cyc; start = 1'b1; mode = 1'b1; scalar_in = 32'hDEADBEEF;
    push_bytes(scalar_in, 4, 1'b0);
    for (int r = 1; r <= 4; r++) lit(r, S_TXV, 1);
    lit(1, S_TXD, 32'hDE); lit(4, S_TXD, 32'hEF); lit(4, S_DONE, 0);
    lit(5, S_DONE, 1); lit(5, S_TXV, 0); lit(4, S_BUSY, 1); lit(6, S_BUSY, 0);
    done_exp++;
    tick(); start = 1'b0; mode = 1'b0;
    repeat (8) tick();

    // Vector of four elements
    t0 = cyc; start = 1'b1; mode = 1'b0;
    push_vector();
    lit(1, S_RDEN, 1); lit(1, S_RDADDR, 0); lit(2, S_RDEN, 0); lit(3, S_TXV, 0);
    lit(4, S_TXV, 1); lit(4, S_TXD, 32'h01); lit(6, S_RDEN, 1); lit(6, S_RDADDR, 1);
    lit(20, S_TXD, 32'h08); lit(20, S_DONE, 0); lit(21, S_DONE, 1); lit(22, S_BUSY, 0);
    done_exp++;
    tick(); start = 1'b0;
    repeat (24) tick();

    // Backpressure on the first scalar byte
    t0 = cyc; start = 1'b1; mode = 1'b1; scalar_in = 32'h11223344; tx_ready = 1'b0;
    push_bytes(scalar_in, 4, 1'b0);
    for (int r = 1; r <= 5; r++) begin
      lit(r, S_TXV, 1);
      lit(r, S_TXD, 32'h11);
    end
    lit(6, S_TXD, 32'h11); lit(7, S_TXD, 32'h22); lit(9, S_TXD, 32'h44);
    lit(10, S_DONE, 1); lit(11, S_BUSY, 0);
    done_exp++;
    tick(); start = 1'b0; mode = 1'b0;
    repeat (4) tick();
    tick(); tx_ready = 1'b1;
    repeat (8) tick();

    // Start while busy must be ignored
    t0 = cyc; start = 1'b1; mode = 1'b0;
    push_vector();
    lit(21, S_DONE, 1); lit(22, S_BUSY, 0); lit(23, S_BUSY, 0); lit(23, S_TXV, 0);
    done_exp++;
    tick(); start = 1'b0;
    repeat (6) tick();
    start = 1'b1; mode = 1'b1; scalar_in = 32'hFFFFFFFF;
    tick(); start = 1'b0; mode = 1'b0;
    repeat (18) tick();

    // Reset after the third vector byte, then a fresh scalar
    t0 = cyc; start = 1'b1; mode = 1'b0;
    push_vector();
    lit(9, S_TXD, 32'h03);
    lit(11, S_TXV, 0); lit(11, S_BUSY, 0); lit(11, S_DONE, 0);
    lit(11, S_RDEN, 0); lit(11, S_RDADDR, 0); lit(11, S_TXD, 0);
    tick(); start = 1'b0;
    repeat (8) tick();
    tick(); reset = 1'b1;
    exp_q.delete();
    addr_q.delete();
    tick(); reset = 1'b0;
    tick();
    t0 = cyc; start = 1'b1; mode = 1'b1; scalar_in = 32'hA5C30F01;
    push_bytes(scalar_in, 4, 1'b0);
    lit(1, S_TXD, 32'hA5); lit(4, S_TXD, 32'h01); lit(5, S_DONE, 1);
    done_exp++;
    tick(); start = 1'b0; mode = 1'b0;
    repeat (8) tick();

    // Narrow 9-bit element zero-extends into two bytes
    t0 = cyc; n_start = 1'b1;
    push_bytes(32'(n_mem[0]), 2, 1'b1);
    lit(3, S_NTXV, 0); lit(4, S_NTXV, 1); lit(4, S_NTXD, 32'h01);
    lit(5, S_NTXD, 32'hFF); lit(6, S_NDONE, 1);
    tick(); n_start = 1'b0;
    repeat (8) tick();

    chk("bytes_left", 32'(exp_q.size()), 32'd0);
    chk("addrs_left", 32'(addr_q.size()), 32'd0);
    chk("narrow_bytes_left", 32'(n_exp_q.size()), 32'd0);
    chk("done_count", 32'(done_cnt), 32'(done_exp));
    chk("narrow_done_count", 32'(n_done_cnt), 32'd1);
    chk("lits_left", 32'(lit_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
